// File: rtl/aesl_axis_block_detector.sv
// Per-channel AXI-Stream stall detector that feeds the deadlock monitor's blocking vector.
// Define AESL_BLOCK_INFO_EN to add the block_info port with per-channel longest-stall records.
module aesl_axis_block_detector #(
  parameter int unsigned          NUM_CH       = 10,
  parameter logic [NUM_CH-1:0]    CH_IS_OUT    = '0,
  parameter int unsigned          STALL_W      = 10,
  parameter int unsigned          STALL_THRESH = 256,
  localparam int unsigned         CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    mon_en,
  input  logic                    clear,
  input  logic [NUM_CH-1:0]       tvalid,
  input  logic [NUM_CH-1:0]       tready,
  output logic [NUM_CH-1:0]       axis_block_sigs,
  output logic                    any_block,
  output logic                    first_blk_valid,
  output logic [CH_W-1:0]         first_blk_ch
`ifdef AESL_BLOCK_INFO_EN
  ,
  output logic [NUM_CH*STALL_W-1:0] block_info
`endif
);

  localparam logic [STALL_W-1:0] THRESH  = STALL_W'(STALL_THRESH);
  localparam logic [STALL_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0][STALL_W-1:0] cnt_q;
  logic [NUM_CH-1:0][STALL_W-1:0] cnt_d;
  logic [NUM_CH-1:0]              waiting;
  logic [NUM_CH-1:0]              handshake;
  logic [NUM_CH-1:0]              flag_d;
  logic [NUM_CH-1:0]              rising;
  logic [CH_W-1:0]                first_idx;
  logic                           found;

  always_comb begin
    waiting   = (CH_IS_OUT & tvalid & ~tready) | (~CH_IS_OUT & tready & ~tvalid);
    handshake = tvalid & tready;
    cnt_d     = '0;
    flag_d    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      // Increment only on a definite stall; an X anywhere falls through to the cleared value.
      if (!clear && mon_en && waiting[i] && !handshake[i]) begin
        cnt_d[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + STALL_W'(1);
      end
      flag_d[i] = (cnt_d[i] >= THRESH);
    end
  end

  always_comb begin
    rising    = flag_d & ~axis_block_sigs;
    first_idx = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rising[i] && !found) begin
        first_idx = CH_W'(i);
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q           <= '0;
      axis_block_sigs <= '0;
      any_block       <= 1'b0;
      first_blk_valid <= 1'b0;
      first_blk_ch    <= '0;
    end else begin
      cnt_q           <= cnt_d;
      axis_block_sigs <= flag_d;
      any_block       <= |flag_d;
      if (clear) begin
        first_blk_valid <= 1'b0;
        first_blk_ch    <= '0;
      end else if (!first_blk_valid && found) begin
        first_blk_valid <= 1'b1;
        first_blk_ch    <= first_idx;
      end
    end
  end

`ifdef AESL_BLOCK_INFO_EN
  logic [NUM_CH-1:0][STALL_W-1:0] max_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      max_q <= '0;
    end else if (clear) begin
      max_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (cnt_d[i] > max_q[i]) max_q[i] <= cnt_d[i];
      end
    end
  end

  assign block_info = max_q;
`endif

endmodule
